// File: rtl/matrix_scan.sv
// matrix_scan: column-multiplexed driver for a gs x gs LED matrix.
//   Latches a flat frame from the game logic, scans it one column at a time,
//   and after FRAMES full refreshes pulses e_act_o so the game logic can
//   compute its next step.
//
// Ports
//   clk_i       in   1      system clock
//   reset_ni    in   1      synchronous reset, active low
//   matrix_i    in   gs*gs  frame from game logic; bit x*gs+y = column x, row y
//   d_act_i     in   1      frame valid; matrix_i may be latched
//   col_sel_o   out  gs     one-hot column select (all-zero outside SCAN)
//   row_data_o  out  gs     row levels for the selected column
//   e_act_o     out  1      one-cycle request for the next game step
//   scan_o      out  1      high while scanning
//
// Optional feature macro: SCAN_BLANK_EN
//   When defined, row_data_o is blanked during the first cycle (dwell==0) of
//   every column to suppress ghosting. Column timing is unaffected.
module matrix_scan #(
  parameter int unsigned gs     = 8,
  parameter int unsigned DIV_W  = 10,
  parameter int unsigned FRAMES = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [gs*gs-1:0] matrix_i,
  input  logic             d_act_i,
  output logic [gs-1:0]    col_sel_o,
  output logic [gs-1:0]    row_data_o,
  output logic             e_act_o,
  output logic             scan_o
);

  localparam int unsigned CW = (gs > 1) ? $clog2(gs) : 1;
  localparam int unsigned FW = 8;
  localparam int unsigned MW = gs * gs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   frame_q, frame_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;

  logic [gs-1:0]   col_sel_d;
  logic [gs-1:0]   row_data_d;
  logic            e_act_d;
  logic            scan_d;

  // State, counters, frame buffer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      col_q      <= '0;
      dwell_q    <= '0;
      fcnt_q     <= '0;
      col_sel_o  <= '0;
      row_data_o <= '0;
      e_act_o    <= 1'b0;
      scan_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      col_q      <= col_d;
      dwell_q    <= dwell_d;
      fcnt_q     <= fcnt_d;
      col_sel_o  <= col_sel_d;
      row_data_o <= row_data_d;
      e_act_o    <= e_act_d;
      scan_o     <= scan_d;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (d_act_i) begin
          frame_d = matrix_i;
          col_d   = '0;
          dwell_d = '0;
          fcnt_d  = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        // dwell is exactly DIV_W bits, so the increment wraps at D-1 on its own.
        dwell_d = dwell_q + DIV_W'(1);
        if (&dwell_q) begin
          if (col_q == CW'(gs - 1)) begin
            col_d = '0;
            if (fcnt_q == FW'(FRAMES - 1)) begin
              fcnt_d  = '0;
              state_d = S_REQ;
            end else begin
              fcnt_d = fcnt_q + FW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Game logic advanced on the REQ edge; take its frame only if valid.
        if (d_act_i) begin
          frame_d = matrix_i;
        end
        col_d   = '0;
        dwell_d = '0;
        state_d = S_SCAN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from next-state values so they change on the same edge.
  always_comb begin
    col_sel_d  = '0;
    row_data_d = '0;
    e_act_d    = (state_d == S_REQ);
    scan_d     = (state_d == S_SCAN);

    if (state_d == S_SCAN) begin
      col_sel_d  = gs'(1) << col_d;
      row_data_d = frame_d[32'(col_d) * gs +: gs];
`ifdef SCAN_BLANK_EN
      if (dwell_d == '0) begin
        row_data_d = '0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed + randomized bench for matrix_scan (gs=8, D=4, FRAMES=2).
// The reference model tracks only "running or idle", the position inside one
// refresh period (SCAN_LEN scan cycles, then REQ, then WAIT) and the displayed frame.
module tb_matrix_scan;

  localparam int GS       = 8;
  localparam int DW       = 2;
  localparam int D        = 4;
  localparam int FR       = 2;
  localparam int SCAN_LEN = FR * GS * D;
`ifdef SCAN_BLANK_EN
  localparam int DIAG_LIT = D - 1;
`else
  localparam int DIAG_LIT = D;
`endif

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic [GS*GS-1:0] matrix_i;
  logic             d_act_i;
  logic [GS-1:0]    col_sel_o;
  logic [GS-1:0]    row_data_o;
  logic             e_act_o;
  logic             scan_o;

  matrix_scan #(.gs(GS), .DIV_W(DW), .FRAMES(FR)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .matrix_i   (matrix_i),
    .d_act_i    (d_act_i),
    .col_sel_o  (col_sel_o),
    .row_data_o (row_data_o),
    .e_act_o    (e_act_o),
    .scan_o     (scan_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit               m_run   = 1'b0;
  int               m_phase = 0;
  logic [GS*GS-1:0] m_frame = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_col();
    return (m_phase / D) % GS;
  endfunction

  function automatic logic [GS-1:0] exp_col_sel();
    logic [GS-1:0] one;
    one = GS'(1);
    if (m_run && m_phase < SCAN_LEN) return one << m_col();
    return '0;
  endfunction

  function automatic logic [GS-1:0] exp_row();
    logic [GS-1:0] r;
    if (!(m_run && m_phase < SCAN_LEN)) return '0;
    r = m_frame[m_col() * GS +: GS];
`ifdef SCAN_BLANK_EN
    if (m_phase % D == 0) r = '0;
`endif
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (!reset_ni) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (d_act_i) begin
        m_run   = 1'b1;
        m_phase = 0;
        m_frame = matrix_i;
      end
    end else if (m_phase == SCAN_LEN + 1) begin
      if (d_act_i) m_frame = matrix_i;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  // One clock: update the model at the edge, then compare every output 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check("col_sel", 64'(col_sel_o), 64'(exp_col_sel()));
    check("row_data", 64'(row_data_o), 64'(exp_row()));
    check("e_act", 64'(e_act_o), 64'(m_run && m_phase == SCAN_LEN));
    check("scan", 64'(scan_o), 64'(m_run && m_phase < SCAN_LEN));
  endtask

  function automatic logic [GS*GS-1:0] rand_frame();
    return {$urandom(), $urandom()};
  endfunction

  int n;
  int diag_cnt [GS];
  logic [GS*GS-1:0] diag;
  logic [GS-1:0] one_x;

  initial begin
    // 1. Reset held low with d_act high -> all outputs zero; release -> scanning column 0.
    reset_ni = 1'b0;
    d_act_i  = 1'b1;
    matrix_i = rand_frame();
    #1;
    for (int i = 0; i < 3; i++) step();
    check("rst_col_sel", 64'(col_sel_o), 64'h0);
    check("rst_scan", 64'(scan_o), 64'h0);
    reset_ni = 1'b1;
    step();
    check("rel_scan", 64'(scan_o), 64'h1);
    check("rel_col_sel", 64'(col_sel_o), 64'h01);

    // 2. Idle with d_act low for 20 cycles, then start.
    reset_ni = 1'b0;
    step();
    reset_ni = 1'b1;
    d_act_i  = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      matrix_i = rand_frame();
      step();
      if (e_act_o !== 1'b0 || col_sel_o !== '0) n++;
    end
    check("idle_quiet", 64'(n), 64'h0);
    d_act_i = 1'b1;
    step();
    check("idle_start_scan", 64'(scan_o), 64'h1);

    // 3. Diagonal frame: column x lights only row x, for D cycles (D-1 when blanking).
    reset_ni = 1'b0;
    step();
    reset_ni = 1'b1;
    diag = '0;
    for (int x = 0; x < GS; x++) diag[x * GS + x] = 1'b1;
    matrix_i = diag;
    d_act_i  = 1'b1;
    for (int x = 0; x < GS; x++) diag_cnt[x] = 0;
    for (int i = 0; i < GS * D; i++) begin
      step();
      for (int x = 0; x < GS; x++) begin
        one_x = GS'(1) << x;
        if (col_sel_o === one_x && row_data_o === one_x) diag_cnt[x]++;
      end
    end
    for (int x = 0; x < GS; x++) check($sformatf("diag_col%0d", x), 64'(diag_cnt[x]), 64'(DIAG_LIT));

    // 4. Free run: first request on the 65th cycle counting scan entry as cycle 1,
    //    then every SCAN_LEN+2 cycles, each one cycle wide.
    reset_ni = 1'b0;
    step();
    reset_ni = 1'b1;
    matrix_i = rand_frame();
    d_act_i  = 1'b1;
    step();
    n = 0;
    while (e_act_o !== 1'b1 && n < 200) begin
      matrix_i = rand_frame();
      d_act_i  = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("first_eact_delay", 64'(n), 64'(SCAN_LEN));
    for (int k = 0; k < 2; k++) begin
      step();
      check("eact_width", 64'(e_act_o), 64'h0);
      n = 1;
      while (e_act_o !== 1'b1 && n < 200) begin
        matrix_i = rand_frame();
        d_act_i  = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check("eact_period", 64'(n), 64'(SCAN_LEN + 2));
    end

    // 5. Random frame changes and d_act toggling at every point of the period.
    for (int i = 0; i < 500; i++) begin
      matrix_i = rand_frame();
      d_act_i  = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // 6a. Reset while in REQ.
    d_act_i = 1'b1;
    n = 0;
    while (e_act_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("reach_req", 64'(e_act_o), 64'h1);
    reset_ni = 1'b0;
    step();
    check("req_rst_col_sel", 64'(col_sel_o), 64'h0);
    check("req_rst_row", 64'(row_data_o), 64'h0);
    check("req_rst_eact", 64'(e_act_o), 64'h0);
    check("req_rst_scan", 64'(scan_o), 64'h0);
    reset_ni = 1'b1;
    d_act_i  = 1'b0;
    step();
    check("req_rst_idle", 64'(scan_o), 64'h0);

    // 6b. Reset in the middle of a column (column 2, second dwell cycle).
    matrix_i = rand_frame();
    d_act_i  = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("mid_col_sel", 64'(col_sel_o), 64'h04);
    reset_ni = 1'b0;
    step();
    check("mid_rst_col_sel", 64'(col_sel_o), 64'h0);
    check("mid_rst_row", 64'(row_data_o), 64'h0);
    check("mid_rst_scan", 64'(scan_o), 64'h0);
    reset_ni = 1'b1;
    for (int i = 0; i < 40; i++) begin
      matrix_i = rand_frame();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
